csr_file_m: RTL and testbench
=============================

Name: csr_file_m

Overview:
- Parametrised machine-mode CSR file for the RV32 core; the successor to the read-only/counter-only CSR block.
- Adds writable trap CSRs, hardware trap entry and mret update, interrupt-pending sampling, mcountinhibit, and NUM_HPM generic performance counters.
- Sits at writeback. The execute stage reads it combinationally; writeback and the trap controller update it.

Parameters:
- NUM_HPM, 4, number of mhpmcounterN implemented (N = 3..3+NUM_HPM-1); legal range 0..29.
- HPM_WIDTH, 40, width of each hpm counter; legal range 1..64. Bits at and above HPM_WIDTH read 0.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- raddr_i  in  12  CSR read address
- rdata_o  out  32  CSR read data (combinational)
- rillegal_o  out  1  raddr_i is unimplemented (combinational)
- we_i  in  1  CSR write enable
- waddr_i  in  12  CSR write address
- wdata_i  in  32  CSR write data
- instret_incr_i  in  1  one instruction retired this cycle
- hpm_event_i  in  NUM_HPM  event pulse per hpm counter (bit k drives mhpmcounter(3+k))
- trap_i  in  1  take trap this cycle
- trap_cause_i  in  32  mcause value; bit31 set = interrupt
- trap_pc_i  in  32  faulting PC
- trap_val_i  in  32  mtval value
- mret_i  in  1  mret retiring this cycle
- irq_ext_i  in  1  external interrupt level
- irq_timer_i  in  1  timer interrupt level
- irq_sw_i  in  1  software interrupt level
- trap_target_o  out  32  PC to redirect to on trap (combinational from mtvec and trap_cause_i)
- mepc_o  out  32  current mepc, used by mret
- irq_req_o  out  1  mstatus.MIE & |(mie & mip) over bits 3/7/11

Behaviour:
- Reset (asynchronous, rst_i=1): all of the following are set at once.
  - mcycle, minstret, all hpm counters, mscratch, mepc, mcause, mtval, mie, mip, mcountinhibit = 0.
  - mtvec = MTVEC_RESET; mstatus = 32'h0000_1800 (MPP=11, MIE=0, MPIE=0).
  - Outputs on reset: irq_req_o=0, mepc_o=0, trap_target_o derives from MTVEC_RESET.
- Read is combinational.
  - If we_i and waddr_i==raddr_i, rdata_o = wdata_i after the write mask is applied (bypass).
  - Read-only IDs: mvendorid=0, marchid=22, mimpid=0, mhartid=HART_ID. misa = MXL 01, extensions I+M.
  - mhpmeventN reads the constant N; writes to it are ignored.
  - Any unlisted address reads 0 with rillegal_o=1.
- Write masks (WARL):
  - mstatus: only MIE(3), MPIE(7) and MPP(12:11) are writable; MPP always reads 11.
  - mie, mip: only bits 3/7/11 are implemented. mip is read-only to software.
  - mepc[1:0]=0. mtvec[1:0]: value 1x is stored as 00.
  - mcountinhibit: bits 0 and 2 are writable, plus bits 3..3+NUM_HPM-1.
- Counters:
  - mcycle increments every cycle unless inhibit[0]. minstret increments on instret_incr_i unless inhibit[2]. hpm k increments on hpm_event_i[k] unless inhibit[3+k].
  - All counters wrap modulo 2^width.
  - Low/high halves are writable (mcycle/mcycleh, minstret/minstreth, mhpmcounterN/Nh). cycle/cycleh/instret/instreth are read-only aliases.
  - A software write to a half replaces that half; the other half keeps its value and the increment is suppressed that cycle.
- mip: MEIP/MTIP/MSIP are registered from irq_ext_i/irq_timer_i/irq_sw_i every cycle, so there is one cycle of latency.
- Trap (trap_i=1), registered on the next edge:
  - mepc<=trap_pc_i&~3, mcause<=trap_cause_i, mtval<=trap_val_i.
  - MPIE<=MIE, MIE<=0, MPP<=11.
- mret (mret_i=1): MIE<=MPIE, MPIE<=1, MPP<=11.
- Same-cycle priority: trap_i > mret_i > we_i.
  - A CSR write colliding with a trap or mret is dropped only for the fields those events update (mstatus, mepc, mcause, mtval); writes to other CSRs proceed.
  - trap_i and mret_i both high: the trap wins and mret is ignored.
- trap_target_o:
  - mtvec mode 00, or trap_cause_i[31]=0: {mtvec[31:2],2'b00}.
  - mode 01 and interrupt: {mtvec[31:2],2'b00} + 4*trap_cause_i[4:0].
- Reset asserted mid-operation aborts any pending update; the reset values hold until release.

Optional Feature:
- CSR_HPM_EN defined: the NUM_HPM hpm counters, their events and their inhibit bits exist as above.
- Not defined: no hpm registers are built. mhpmcounterN/Nh and mhpmeventN read 0 with rillegal_o=0; writes are ignored; mcountinhibit[31:3] read 0; hpm_event_i is unused.

Test Plan:
- Reset, release, run 10 cycles -> read mcycle=10, mtvec=MTVEC_RESET, mstatus=32'h1800.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0, then run 1 cycle -> mcycle=0, mcycleh=1. Set mcountinhibit=1 -> mcycle frozen.
- mstatus.MIE=1, trap_i with cause 32'h8000_0007, pc 32'h100 -> mepc=32'h100, mcause=32'h8000_0007, MIE=0, MPIE=1. Next mret -> MIE=1.
- mtvec=32'h0000_2001, interrupt cause 11 -> trap_target_o=32'h202C. Exception cause 2 -> 32'h2000.
- irq_timer_i=1 with mie=32'h80 and MIE=1 -> irq_req_o=1 exactly one cycle later; mip reads 32'h80.
- Same cycle: we_i to mepc=32'h44 and trap_i with pc 32'h200 -> mepc=32'h200. Same cycle: we_i to mscratch and trap_i -> mscratch written.

Source files
------------

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file for the RV32 core (trap CSRs, counters, interrupt sampling).
// Define CSR_HPM_EN to build the NUM_HPM mhpmcounter/mhpmevent registers and their inhibit bits.
`timescale 1ns/1ps

module csr_hpm_cnt #(
   parameter int W = 40
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] val_o
);
   logic [W-1:0] cnt_q, nxt;

   for (genvar i = 0; i < W; i++) begin : g_bit
      if (i < 32) begin : g_lo
         assign nxt[i] = wr_lo_i ? wdata_i[i] : cnt_q[i];
      end else begin : g_hi
         assign nxt[i] = wr_hi_i ? wdata_i[i-32] : cnt_q[i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i)                  cnt_q <= '0;
      else if (wr_lo_i || wr_hi_i) cnt_q <= nxt;
      else if (inc_i)             cnt_q <= cnt_q + W'(1);

   always_comb begin
      val_o          = '0;
      val_o[W-1:0]   = cnt_q;
   end
endmodule

module csr_file_m #(
   parameter int          NUM_HPM     = 4,
   parameter int          HPM_WIDTH   = 40,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'd0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [11:0]        raddr_i,
   output logic [31:0]        rdata_o,
   output logic               rillegal_o,
   input  logic               we_i,
   input  logic [11:0]        waddr_i,
   input  logic [31:0]        wdata_i,
   input  logic               instret_incr_i,
   input  logic [NUM_HPM-1:0] hpm_event_i,
   input  logic               trap_i,
   input  logic [31:0]        trap_cause_i,
   input  logic [31:0]        trap_pc_i,
   input  logic [31:0]        trap_val_i,
   input  logic               mret_i,
   input  logic               irq_ext_i,
   input  logic               irq_timer_i,
   input  logic               irq_sw_i,
   output logic [31:0]        trap_target_o,
   output logic [31:0]        mepc_o,
   output logic               irq_req_o
);
   localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304, A_MTVEC = 12'h305;
   localparam logic [11:0] A_MCOUNTINH = 12'h320, A_MHPME = 12'h323, A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
   localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02, A_HPM_LO = 12'hB03;
   localparam logic [11:0] A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82, A_HPM_HI = 12'hB83;
   localparam logic [11:0] A_CYCLE = 12'hC00, A_INSTRET = 12'hC02, A_CYCLEH = 12'hC80, A_INSTRETH = 12'hC82;
   localparam logic [11:0] A_MVENDORID = 12'hF11, A_MARCHID = 12'hF12, A_MIMPID = 12'hF13, A_MHARTID = 12'hF14;
   localparam int          NH       = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam logic [31:0] IRQ_MASK = 32'h0000_0888;
`ifdef CSR_HPM_EN
   localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
   localparam logic [63:0] HPM_MASK = (HPM_WIDTH >= 64) ? {64{1'b1}} : ((64'd1 << HPM_WIDTH) - 64'd1);
`else
   localparam logic [31:0] INH_MASK = 32'h5;
`endif

   logic [63:0] mcycle_q, minstret_q;
   logic [31:0] mscratch_q, mepc_q, mcause_q, mtval_q, mtvec_q, mie_q, mip_q, inh_q;
   logic        mst_mie_q, mst_mpie_q;
   logic [31:0] mstatus, wval, rd_raw, tvec_base;
   logic        wok;

   assign mstatus = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};

   // Value a software write would leave in the CSR; shared by the registers and the read bypass.
   always_comb begin
      wval = wdata_i;
      wok  = 1'b1;
      case (waddr_i)
         A_MSTATUS:   wval = {19'b0, 2'b11, 3'b0, wdata_i[7], 3'b0, wdata_i[3], 3'b0};
         A_MIE:       wval = wdata_i & IRQ_MASK;
         A_MTVEC:     wval = wdata_i[1] ? {wdata_i[31:2], 2'b00} : wdata_i;
         A_MCOUNTINH: wval = wdata_i & INH_MASK;
         A_MEPC:      wval = wdata_i & ~32'h3;
         A_MSCRATCH, A_MCAUSE, A_MTVAL, A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: ;
         default: begin
            wok = 1'b0;
`ifdef CSR_HPM_EN
            for (int k = 0; k < NUM_HPM; k++) begin
               if (waddr_i == A_HPM_LO + 12'(k)) begin wval = wdata_i & HPM_MASK[31:0];  wok = 1'b1; end
               if (waddr_i == A_HPM_HI + 12'(k)) begin wval = wdata_i & HPM_MASK[63:32]; wok = 1'b1; end
            end
`endif
         end
      endcase
   end

`ifdef CSR_HPM_EN
   logic [NH-1:0][63:0] hpm_val;
   for (genvar k = 0; k < NUM_HPM; k++) begin : g_hpm
      csr_hpm_cnt #(.W(HPM_WIDTH)) u_cnt (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .inc_i   (hpm_event_i[k] & ~inh_q[3+k]),
         .wr_lo_i (we_i && waddr_i == A_HPM_LO + 12'(k)),
         .wr_hi_i (we_i && waddr_i == A_HPM_HI + 12'(k)),
         .wdata_i (wdata_i),
         .val_o   (hpm_val[k])
      );
   end
`else
   logic unused_hpm;
   assign unused_hpm = ^hpm_event_i;
`endif

   // Trap beats mret beats software write for the trap-owned fields.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mepc_q <= '0; mcause_q <= '0; mtval_q <= '0; mst_mie_q <= 1'b0; mst_mpie_q <= 1'b0;
      end else if (trap_i) begin
         mepc_q     <= trap_pc_i & ~32'h3;
         mcause_q   <= trap_cause_i;
         mtval_q    <= trap_val_i;
         mst_mpie_q <= mst_mie_q;
         mst_mie_q  <= 1'b0;
      end else if (mret_i) begin
         mst_mie_q  <= mst_mpie_q;
         mst_mpie_q <= 1'b1;
      end else if (we_i) begin
         case (waddr_i)
            A_MSTATUS: begin mst_mie_q <= wval[3]; mst_mpie_q <= wval[7]; end
            A_MEPC:    mepc_q   <= wval;
            A_MCAUSE:  mcause_q <= wval;
            A_MTVAL:   mtval_q  <= wval;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mscratch_q <= '0; mie_q <= '0; mip_q <= '0; inh_q <= '0;
         mtvec_q <= MTVEC_RESET; mcycle_q <= '0; minstret_q <= '0;
      end else begin
         mip_q <= {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};
         if (we_i) begin
            case (waddr_i)
               A_MSCRATCH:  mscratch_q <= wval;
               A_MIE:       mie_q      <= wval;
               A_MTVEC:     mtvec_q    <= wval;
               A_MCOUNTINH: inh_q      <= wval;
               default: ;
            endcase
         end
         if (we_i && (waddr_i == A_MCYCLE || waddr_i == A_MCYCLEH)) begin
            if (waddr_i == A_MCYCLE) mcycle_q[31:0]  <= wdata_i;
            else                     mcycle_q[63:32] <= wdata_i;
         end else if (!inh_q[0]) mcycle_q <= mcycle_q + 64'd1;
         if (we_i && (waddr_i == A_MINSTRET || waddr_i == A_MINSTRETH)) begin
            if (waddr_i == A_MINSTRET) minstret_q[31:0]  <= wdata_i;
            else                       minstret_q[63:32] <= wdata_i;
         end else if (instret_incr_i && !inh_q[2]) minstret_q <= minstret_q + 64'd1;
      end
   end

   always_comb begin
      rd_raw     = '0;
      rillegal_o = 1'b0;
      case (raddr_i)
         A_MSTATUS:             rd_raw = mstatus;
         A_MISA:                rd_raw = 32'h4000_1100;
         A_MIE:                 rd_raw = mie_q;
         A_MTVEC:               rd_raw = mtvec_q;
         A_MCOUNTINH:           rd_raw = inh_q;
         A_MSCRATCH:            rd_raw = mscratch_q;
         A_MEPC:                rd_raw = mepc_q;
         A_MCAUSE:              rd_raw = mcause_q;
         A_MTVAL:               rd_raw = mtval_q;
         A_MIP:                 rd_raw = mip_q;
         A_MCYCLE, A_CYCLE:     rd_raw = mcycle_q[31:0];
         A_MCYCLEH, A_CYCLEH:   rd_raw = mcycle_q[63:32];
         A_MINSTRET, A_INSTRET: rd_raw = minstret_q[31:0];
         A_MINSTRETH, A_INSTRETH: rd_raw = minstret_q[63:32];
         A_MVENDORID, A_MIMPID: rd_raw = '0;
         A_MARCHID:             rd_raw = 32'd22;
         A_MHARTID:             rd_raw = HART_ID;
         default: begin
            // The whole mhpmevent/mhpmcounter(h) 3..31 window is legal; unbuilt ones read 0.
            if (raddr_i[4:0] >= 5'd3 &&
                (raddr_i[11:5] == 7'h19 || raddr_i[11:5] == 7'h58 || raddr_i[11:5] == 7'h5C)) begin
`ifdef CSR_HPM_EN
               for (int k = 0; k < NUM_HPM; k++) begin
                  if (raddr_i == A_MHPME + 12'(k))  rd_raw = 32'(k + 3);
                  if (raddr_i == A_HPM_LO + 12'(k)) rd_raw = hpm_val[k][31:0];
                  if (raddr_i == A_HPM_HI + 12'(k)) rd_raw = hpm_val[k][63:32];
               end
`endif
            end else begin
               rillegal_o = 1'b1;
            end
         end
      endcase
   end

   assign rdata_o       = (we_i && wok && waddr_i == raddr_i) ? wval : rd_raw;
   assign tvec_base     = {mtvec_q[31:2], 2'b00};
   assign trap_target_o = (mtvec_q[1:0] == 2'b01 && trap_cause_i[31])
                          ? tvec_base + {25'b0, trap_cause_i[4:0], 2'b00} : tvec_base;
   assign mepc_o        = mepc_q;
   assign irq_req_o     = mst_mie_q & |(mie_q & mip_q & IRQ_MASK);
endmodule

// File: tb/tb_csr_file_m.sv
// Directed-vector bench for csr_file_m with hand-computed expectations.
`timescale 1ns/1ps

module tb_csr_file_m;
   logic        clk_i = 1'b0, rst_i;
   logic [11:0] raddr_i, waddr_i;
   logic [31:0] rdata_o, wdata_i, trap_cause_i, trap_pc_i, trap_val_i, trap_target_o, mepc_o;
   logic        rillegal_o, we_i, instret_incr_i, trap_i, mret_i, irq_ext_i, irq_timer_i, irq_sw_i, irq_req_o;
   logic [3:0]  hpm_event_i;
   int          n_cmp = 0, n_bad = 0;

   always #10 clk_i = ~clk_i;

   csr_file_m #(.NUM_HPM(4), .HPM_WIDTH(40), .MTVEC_RESET(32'h0000_1000), .HART_ID(32'd5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .rillegal_o(rillegal_o),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .instret_incr_i(instret_incr_i),
      .hpm_event_i(hpm_event_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
      .trap_val_i(trap_val_i), .mret_i(mret_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
      .irq_sw_i(irq_sw_i), .trap_target_o(trap_target_o), .mepc_o(mepc_o), .irq_req_o(irq_req_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      raddr_i = a;
      #1;
      chk(tag, rdata_o, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; wdata_i = d;
      @(negedge clk_i);
      we_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; raddr_i = '0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; instret_incr_i = 1'b0;
      hpm_event_i = '0; trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; trap_val_i = '0;
      mret_i = 1'b0; irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_sw_i = 1'b0;

      chk_rd("rst_mcycle", 12'hB00, 32'h0);
      chk_rd("rst_mstatus", 12'h300, 32'h1800);
      chk_rd("rst_mtvec", 12'h305, 32'h1000);
      chk("rst_irq_req", {31'b0, irq_req_o}, 32'h0);
      chk("rst_mepc_o", mepc_o, 32'h0);
      chk("rst_trap_target", trap_target_o, 32'h1000);
      chk_rd("mhartid", 12'hF14, 32'd5);
      chk_rd("misa", 12'h301, 32'h4000_1100);
      @(negedge clk_i);
      chk_rd("marchid", 12'hF12, 32'd22);
      chk_rd("illegal_data", 12'h7C0, 32'h0);
      chk("illegal_flag", {31'b0, rillegal_o}, 32'h1);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (10) @(negedge clk_i);
      chk_rd("mcycle_10", 12'hB00, 32'd10);
      chk_rd("mcycleh_0", 12'hB80, 32'h0);

      // 64-bit carry across the halves
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0);
      @(negedge clk_i);
      chk_rd("mcycle_wrap_lo", 12'hB00, 32'h0);
      chk_rd("mcycle_wrap_hi", 12'hB80, 32'h1);

      we_i = 1'b1; waddr_i = 12'h300; wdata_i = 32'hFFFF_FFFF;
      chk_rd("byp_mstatus", 12'h300, 32'h1888);
      waddr_i = 12'h341; wdata_i = 32'h123;
      chk_rd("byp_mepc", 12'h341, 32'h120);
      we_i = 1'b0;

      wr(12'h320, 32'h1);
      chk_rd("inhibit_lo", 12'hB00, 32'h1);
      repeat (3) @(negedge clk_i);
      chk_rd("frozen_lo", 12'hB00, 32'h1);
      chk_rd("cycle_alias", 12'hC00, 32'h1);
      instret_incr_i = 1'b1;
      repeat (3) @(negedge clk_i);
      instret_incr_i = 1'b0;
      chk_rd("minstret", 12'hB02, 32'd3);
      chk_rd("instret_alias", 12'hC02, 32'd3);

`ifdef CSR_HPM_EN
      hpm_event_i = 4'b0101;
      repeat (2) @(negedge clk_i);
      hpm_event_i = 4'b0000;
      chk_rd("hpm3", 12'hB03, 32'd2);
      chk_rd("hpm4", 12'hB04, 32'd0);
      chk_rd("hpm5", 12'hB05, 32'd2);
      chk_rd("hpmevent4", 12'h324, 32'd4);
      wr(12'hB83, 32'hFFFF_FFFF);
      chk_rd("hpm3h_width", 12'hB83, 32'h0000_00FF);
      chk_rd("hpm3_lo_kept", 12'hB03, 32'd2);
      wr(12'h320, 32'hFFFF_FFFF);
      chk_rd("inhibit_mask", 12'h320, 32'h7D);
`else
      hpm_event_i = 4'b1111;
      repeat (2) @(negedge clk_i);
      hpm_event_i = 4'b0000;
      chk_rd("hpm3_absent", 12'hB03, 32'h0);
      chk("hpm3_legal", {31'b0, rillegal_o}, 32'h0);
      wr(12'h320, 32'hFFFF_FFFF);
      chk_rd("inhibit_mask", 12'h320, 32'h5);
`endif

      wr(12'h300, 32'h8);
      chk_rd("mstatus_mie", 12'h300, 32'h1808);
      trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h100; trap_val_i = 32'hDEAD;
      @(negedge clk_i);
      trap_i = 1'b0;
      chk_rd("trap_mepc", 12'h341, 32'h100);
      chk("trap_mepc_o", mepc_o, 32'h100);
      chk_rd("trap_mcause", 12'h342, 32'h8000_0007);
      chk_rd("trap_mtval", 12'h343, 32'hDEAD);
      chk_rd("trap_mstatus", 12'h300, 32'h1880);
      mret_i = 1'b1;
      @(negedge clk_i);
      mret_i = 1'b0;
      chk_rd("mret_mstatus", 12'h300, 32'h1888);

      wr(12'h305, 32'h2001);
      chk_rd("mtvec_vec", 12'h305, 32'h2001);
      trap_cause_i = 32'h8000_000B;
      #1 chk("vec_target", trap_target_o, 32'h202C);
      trap_cause_i = 32'h2;
      #1 chk("exc_target", trap_target_o, 32'h2000);
      wr(12'h305, 32'h3002);
      chk_rd("mtvec_mode_fix", 12'h305, 32'h3000);

      wr(12'h304, 32'h80);
      irq_timer_i = 1'b1;
      #1 chk("irq_not_yet", {31'b0, irq_req_o}, 32'h0);
      @(negedge clk_i);
      #1 chk("irq_req", {31'b0, irq_req_o}, 32'h1);
      chk_rd("mip", 12'h344, 32'h80);
      irq_timer_i = 1'b0;
      @(negedge clk_i);
      #1 chk("irq_clear", {31'b0, irq_req_o}, 32'h0);

      we_i = 1'b1; waddr_i = 12'h341; wdata_i = 32'h44; trap_i = 1'b1; trap_pc_i = 32'h200;
      @(negedge clk_i);
      we_i = 1'b0; trap_i = 1'b0;
      chk_rd("coll_mepc", 12'h341, 32'h200);
      we_i = 1'b1; waddr_i = 12'h340; wdata_i = 32'hCAFE; trap_i = 1'b1;
      @(negedge clk_i);
      we_i = 1'b0; trap_i = 1'b0;
      chk_rd("coll_mscratch", 12'h340, 32'hCAFE);
      chk_rd("coll_mstatus", 12'h300, 32'h1800);
      trap_i = 1'b1; mret_i = 1'b1;
      @(negedge clk_i);
      trap_i = 1'b0; mret_i = 1'b0;
      chk_rd("trap_over_mret", 12'h300, 32'h1800);

      #3 rst_i = 1'b1;
      #1 chk("arst_mepc_o", mepc_o, 32'h0);
      chk_rd("arst_mscratch", 12'h340, 32'h0);
      chk_rd("arst_mtvec", 12'h305, 32'h1000);
      @(negedge clk_i);
      chk_rd("arst_hold_mcycle", 12'hB00, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
